// File: rtl/gpio_input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_debouncer_pkg
// Brief    : Width helpers shared by the GPIO input debouncer and its bit cell.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_input_debouncer_pkg;

    // Prescaler counts 0..n-1; a single-cycle period still needs one bit.
    function automatic int presc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage : gpio_input_debouncer_pkg
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : gpio_debounce_bit
// Brief    : One-pin stability counter with debounced output and edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_input_debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = 8,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic tick_i,
    input  logic sync_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, fall_q;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (!enable_i) begin
            cnt_d = '0;
            out_d = sync_i;
        end else if (tick_i) begin
            if (sync_i == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                out_d = ~out_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Strobes derive from out_d so they appear in the same cycle as the new level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            out_q  <= RESET_VALUE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule : gpio_debounce_bit
`default_nettype wire

// File: rtl/gpio_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_debouncer
// Brief    : Per-bank pad synchroniser, tick prescaler and per-pin debouncers.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input_debouncer
    import gpio_input_debouncer_pkg::*;
#(
    parameter int               WIDTH        = 5,
    parameter int               PRESCALE     = 100000,
    parameter int               STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic             io_clock,
    input  logic             io_reset_n,
    input  logic             io_enable,
    input  logic [WIDTH-1:0] io_pins_in,
    output logic [WIDTH-1:0] io_pins_out,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
);

    localparam int            PW        = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] sync0_q, sync1_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            sync0_q <= RESET_VALUE;
            sync1_q <= RESET_VALUE;
        end else begin
            sync0_q <= io_pins_in;
            sync1_q <= sync0_q;
        end
    end

    // Held at zero in bypass so re-enabling begins a full prescale period.
    assign tick = io_enable && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if (!io_enable || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VALUE  (RESET_VALUE[i])
        ) u_bit (
            .clk_i    (io_clock),
            .rst_ni   (io_reset_n),
            .enable_i (io_enable),
            .tick_i   (tick),
            .sync_i   (sync1_q[i]),
            .out_o    (io_pins_out[i]),
            .rise_o   (io_rise[i]),
            .fall_o   (io_fall[i])
        );
    end

endmodule : gpio_input_debouncer
`default_nettype wire

// File: tb/tb_gpio_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_debouncer
// Brief    : Directed self-checking bench for gpio_input_debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_debouncer;

    localparam int LAT_MIN = 11;
    localparam int LAT_MAX = 14;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] pins;
    logic [4:0] pout;
    logic [4:0] rise;
    logic [4:0] fall;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rel      = 0;

    gpio_input_debouncer #(
        .WIDTH        (5),
        .PRESCALE     (4),
        .STABLE_TICKS (3),
        .RESET_VALUE  (5'b00000)
    ) dut (
        .io_clock    (clk),
        .io_reset_n  (rst_n),
        .io_enable   (en),
        .io_pins_in  (pins),
        .io_pins_out (pout),
        .io_rise     (rise),
        .io_fall     (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe masked pins for ncyc cycles; first = first cycle they equal tgt.
    task automatic watch(input int ncyc, input logic [4:0] mask, input logic [4:0] tgt,
                         output int first, output int nrise, output int nfall,
                         output int nother, output logic [4:0] rfirst, output logic [4:0] ffirst);
        logic [4:0] base;
        base   = pout & ~mask;
        first  = -1;
        nrise  = 0;
        nfall  = 0;
        nother = 0;
        rfirst = '0;
        ffirst = '0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (first < 0 && ((pout & mask) == (tgt & mask))) begin
                first  = c;
                rfirst = rise;
                ffirst = fall;
            end
            if (|(rise & mask)) nrise++;
            if (|(fall & mask)) nfall++;
            if (((pout & ~mask) != base) || |(rise & ~mask) || |(fall & ~mask)) nother++;
        end
    endtask

    task automatic align_tick();
        for (int g = 0; g < 8 && ((cyc - rel) % 4) != 0; g++) step();
    endtask

    function automatic logic in_lat(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    int         first, nr, nf, no, tr, tf, to;
    logic [4:0] rf, ff;
    logic [7:0] h_out, h_rise, h_fall;
    int         pat[5] = '{1, 0, 1, 1, 0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        pins  = 5'b11111;

        // Reset with all pads high
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq($sformatf("rst_out_c%0d", c), pout, 5'b00000);
            check_eq($sformatf("rst_rise_c%0d", c), rise, 5'b00000);
            check_eq($sformatf("rst_fall_c%0d", c), fall, 5'b00000);
        end
        rst_n = 1'b1;
        rel   = cyc;
        watch(20, 5'b11111, 5'b11111, first, nr, nf, no, rf, ff);
        check_eq($sformatf("rel_lat_ok_%0d", first), in_lat(first), 1'b1);
        check_eq("rel_rise_vec", rf, 5'b11111);
        check_eq("rel_rise_cnt", nr, 1);
        check_eq("rel_fall_cnt", nf, 0);

        pins = 5'b00000;
        watch(20, 5'b11111, 5'b00000, first, nr, nf, no, rf, ff);
        check_eq($sformatf("all_fall_lat_ok_%0d", first), in_lat(first), 1'b1);
        check_eq("all_fall_vec", ff, 5'b11111);
        check_eq("all_fall_cnt", nf, 1);

        // Pin 2 step at four different prescaler phases
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < k; w++) step();
            pins[2] = 1'b1;
            watch(20, 5'b00100, 5'b00100, first, nr, nf, no, rf, ff);
            check_eq($sformatf("p2_rise_lat_ok_k%0d_%0d", k, first), in_lat(first), 1'b1);
            check_eq($sformatf("p2_rise_vec_k%0d", k), rf, 5'b00100);
            check_eq($sformatf("p2_rise_cnt_k%0d", k), nr, 1);
            check_eq($sformatf("p2_other_k%0d", k), no, 0);
            pins[2] = 1'b0;
            watch(20, 5'b00100, 5'b00000, first, nr, nf, no, rf, ff);
            check_eq($sformatf("p2_fall_lat_ok_k%0d_%0d", k, first), in_lat(first), 1'b1);
            check_eq($sformatf("p2_fall_cnt_k%0d", k), nf, 1);
            check_eq($sformatf("p2_fall_other_k%0d", k), no, 0);
        end

        // 6-cycle glitch on pin 0 must be rejected
        pins[0] = 1'b1;
        watch(6, 5'b00001, 5'b00001, first, tr, tf, to, rf, ff);
        check_eq("glitch_early", first, -1);
        pins[0] = 1'b0;
        watch(30, 5'b00001, 5'b00001, first, nr, nf, no, rf, ff);
        check_eq("glitch_out", first, -1);
        check_eq("glitch_rise", nr + tr, 0);
        check_eq("glitch_other", no + to, 0);

        // Bounce train on pin 4, aligned so every low segment spans a tick
        align_tick();
        tr = 0;
        tf = 0;
        for (int s = 0; s < 5; s++) begin
            pins[4] = pat[s][0];
            watch(3, 5'b10000, 5'b10000, first, nr, nf, no, rf, ff);
            tr += nr;
            tf += nf;
        end
        check_eq("bounce_rise_early", tr, 0);
        check_eq("bounce_fall_early", tf, 0);
        pins[4] = 1'b1;
        watch(20, 5'b10000, 5'b10000, first, nr, nf, no, rf, ff);
        check_eq($sformatf("bounce_lat_ok_%0d", first), in_lat(first), 1'b1);
        check_eq("bounce_rise_cnt", nr, 1);
        check_eq("bounce_other", no, 0);

        // Bypass: one-cycle pad pulse on pin 1
        en = 1'b0;
        step();
        pins[1] = 1'b1;
        h_out  = '0;
        h_rise = '0;
        h_fall = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) pins[1] = 1'b0;
            h_out[c]  = pout[1];
            h_rise[c] = rise[1];
            h_fall[c] = fall[1];
        end
        check_eq("byp_out_hist", h_out, 8'b0000_0100);
        check_eq("byp_rise_hist", h_rise, 8'b0000_0100);
        check_eq("byp_fall_hist", h_fall, 8'b0000_1000);
        check_eq("byp_pin4_held", pout, 5'b10000);

        // Reset two ticks into a pin 3 count
        en  = 1'b1;
        rel = cyc;
        align_tick();
        pins[3] = 1'b1;
        watch(8, 5'b01000, 5'b01000, first, nr, nf, no, rf, ff);
        check_eq("midcnt_not_yet", first, -1);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("rst2_out_c%0d", c), pout, 5'b00000);
            check_eq($sformatf("rst2_rise_c%0d", c), rise, 5'b00000);
            check_eq($sformatf("rst2_fall_c%0d", c), fall, 5'b00000);
        end
        rst_n = 1'b1;
        rel   = cyc;
        watch(20, 5'b11000, 5'b11000, first, nr, nf, no, rf, ff);
        check_eq($sformatf("rst2_lat_ok_%0d", first), in_lat(first), 1'b1);
        check_eq("rst2_rise_vec", rf, 5'b11000);
        check_eq("rst2_rise_cnt", nr, 1);
        check_eq("rst2_other", no, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_gpio_input_debouncer
`default_nettype wire
